// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants and types for the UART transmit-side FIFO and its launcher.
package uart_tx_fifo_pkg;

  localparam int DBIT_DEF    = 8;
  localparam int ADDR_W_DEF  = 4;
  localparam int SB_TICK_DEF = 16;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } launch_state_t;

endpackage

// File: rtl/uart_tx_fifo_buffer.sv
// Circular word store with occupancy count, full/empty flags and a one-cycle
// overflow pulse for writes that arrive while full.
module uart_tx_fifo_buffer
  import uart_tx_fifo_pkg::*;
#(
  parameter int DBIT   = DBIT_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DBIT-1:0]   w_data,
  input  logic              rd,
  output logic [DBIT-1:0]   r_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [DBIT-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic              wr_ok;
  logic              rd_ok;

  // Full is judged on the registered count, so a same-cycle pop never rescues a write.
  assign full   = (count == FULL_COUNT);
  assign empty  = (count == '0);
  assign wr_ok  = wr & ~full;
  assign rd_ok  = rd & ~empty;
  assign r_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_ok) begin
        rptr <= rptr + 1'b1;
      end
      count    <= count + {{ADDR_W{1'b0}}, wr_ok} - {{ADDR_W{1'b0}}, rd_ok};
      overflow <= wr & full;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer in front of the UART transmitter: stores host bytes and
// launches them one frame at a time with a registered tx_start pulse.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DBIT   = DBIT_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_uart,
  input  logic [DBIT-1:0]   w_data,
  output logic              tx_full,
  output logic              tx_empty,
  output logic [ADDR_W:0]   tx_count,
  output logic              wr_overflow,
  output logic              tx_start,
  output logic [DBIT-1:0]   tx_din,
  input  logic              tx_done_tick
);

  launch_state_t   state;
  launch_state_t   state_next;
  logic            pop;
  logic            start_next;
  logic [DBIT-1:0] head_data;

  uart_tx_fifo_buffer #(
    .DBIT   (DBIT),
    .ADDR_W (ADDR_W)
  ) u_buffer (
    .clk      (clk),
    .reset    (reset),
    .wr       (wr_uart),
    .w_data   (w_data),
    .rd       (pop),
    .r_data   (head_data),
    .full     (tx_full),
    .empty    (tx_empty),
    .count    (tx_count),
    .overflow (wr_overflow)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      tx_start <= 1'b0;
      tx_din   <= '0;
    end else begin
      state    <= state_next;
      tx_start <= start_next;
      if (pop) begin
        tx_din <= head_data;
      end
    end
  end

  // A done tick that coincides with our own start pulse belongs to the previous frame.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    start_next = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!tx_empty) begin
          pop        = 1'b1;
          start_next = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tx_done_tick && !tx_start) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo: latency, fill/overflow,
// ordered drain with pointer wrap, reset flush and stale done ticks.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_uart = 1'b0;
  logic [7:0] w_data = '0;
  logic       tx_done_tick = 1'b0;
  logic       tx_full;
  logic       tx_empty;
  logic [4:0] tx_count;
  logic       wr_overflow;
  logic       tx_start;
  logic [7:0] tx_din;

  int asserts  = 0;
  int failures = 0;

  uart_tx_fifo #(
    .DBIT   (8),
    .ADDR_W (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_uart      (wr_uart),
    .w_data       (w_data),
    .tx_full      (tx_full),
    .tx_empty     (tx_empty),
    .tx_count     (tx_count),
    .wr_overflow  (wr_overflow),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick)
  );

  always #5 clk = ~clk;

  // Drive inputs for one rising edge, then settle 1 time unit past it.
  task automatic applyStimulus(input logic wr, input logic [7:0] data, input logic done);
    wr_uart      = wr;
    w_data       = data;
    tx_done_tick = done;
    @(posedge clk);
    #1;
    wr_uart      = 1'b0;
    tx_done_tick = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    asserts++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    // Test 1: reset values and single-word latency
    doReset();
    checkOutput("rst_empty", tx_empty, 1);
    checkOutput("rst_full", tx_full, 0);
    checkOutput("rst_count", tx_count, 0);
    checkOutput("rst_start", tx_start, 0);
    checkOutput("rst_din", tx_din, 0);
    checkOutput("rst_ovf", wr_overflow, 0);
    applyStimulus(1'b1, 8'hA5, 1'b0);
    checkOutput("t1_e0_start", tx_start, 0);
    checkOutput("t1_e0_count", tx_count, 1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t1_e1_start", tx_start, 1);
    checkOutput("t1_e1_din", tx_din, 8'hA5);
    checkOutput("t1_e1_empty", tx_empty, 1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t1_e2_start", tx_start, 0);
    checkOutput("t1_e2_din", tx_din, 8'hA5);

    // Test 2: 16 back-to-back writes, one extra accepted, then overflow
    $display("[TB] fill and overflow");
    doReset();
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0);
    end
    checkOutput("t2_count15", tx_count, 15);
    checkOutput("t2_first_din", tx_din, 8'h01);
    checkOutput("t2_not_full", tx_full, 0);
    applyStimulus(1'b1, 8'h11, 1'b0);
    checkOutput("t2_count16", tx_count, 16);
    checkOutput("t2_full", tx_full, 1);
    checkOutput("t2_no_ovf", wr_overflow, 0);
    applyStimulus(1'b1, 8'h12, 1'b0);
    checkOutput("t2_ovf", wr_overflow, 1);
    checkOutput("t2_count_hold", tx_count, 16);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t2_ovf_clear", wr_overflow, 0);

    // Test 3: drain in order across the pointer wrap
    $display("[TB] ordered drain");
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("t3_gap_start", tx_start, 0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("t3_start", tx_start, 1);
      checkOutput("t3_din", tx_din, 32'(k + 2));
      checkOutput("t3_count", tx_count, 32'(15 - k));
      for (int j = 0; j < 3; j++) begin
        applyStimulus(1'b0, 8'h00, 1'b0);
      end
      checkOutput("t3_start_low", tx_start, 0);
    end
    checkOutput("t3_empty", tx_empty, 1);

    // Test 4: write while full, same edge as a pop, is still rejected
    $display("[TB] full write during pop");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'(8'h20 + i), 1'b0);
    end
    checkOutput("t4_full", tx_full, 1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, 8'h99, 1'b0);
    checkOutput("t4_ovf", wr_overflow, 1);
    checkOutput("t4_count", tx_count, 15);
    checkOutput("t4_start", tx_start, 1);
    checkOutput("t4_din", tx_din, 8'h20);

    // Test 5: reset mid-frame flushes the store
    $display("[TB] reset flush");
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'(8'h31 + i), 1'b0);
    end
    checkOutput("t5_count3", tx_count, 3);
    doReset();
    checkOutput("t5_count", tx_count, 0);
    checkOutput("t5_start", tx_start, 0);
    checkOutput("t5_din", tx_din, 0);
    checkOutput("t5_empty", tx_empty, 1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("t5_no_launch", tx_start, 0);
    end

    // Test 6: done tick coinciding with tx_start is stale
    $display("[TB] stale done tick");
    applyStimulus(1'b1, 8'h5A, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t6_start", tx_start, 1);
    applyStimulus(1'b1, 8'h6B, 1'b1);
    checkOutput("t6_start_drop", tx_start, 0);
    checkOutput("t6_count", tx_count, 1);
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("t6_held", tx_start, 0);
    end
    checkOutput("t6_din_hold", tx_din, 8'h5A);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t6_relaunch", tx_start, 1);
    checkOutput("t6_din2", tx_din, 8'h6B);
    checkOutput("t6_count0", tx_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
